// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arb_select.sv
// Grant choice between the instruction and data requesters (combinational).
// With MEM_ARB_RR_EN defined, simultaneous requests go to the requester that
// was not granted last; otherwise data always wins a tie.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic   instr_req,
  input  logic   data_req,
`ifdef MEM_ARB_RR_EN
  input  grant_e last_gnt,
`endif
  output logic   any_req,
  output grant_e gnt
);

  // Pick the winner among the currently asserted requests.
  always_comb begin
    any_req = instr_req | data_req;
    gnt     = GNT_D;
    if (instr_req && !data_req) begin
      gnt = GNT_I;
    end else if (instr_req && data_req) begin
`ifdef MEM_ARB_RR_EN
      gnt = (last_gnt == GNT_D) ? GNT_I : GNT_D;
`else
      gnt = GNT_D;
`endif
    end else begin
      gnt = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between an instruction-fetch requester and
// a data load/store requester. Optional macro MEM_ARB_RR_EN replaces the fixed
// data-first tie-break with alternation based on a last-grant flag.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_req,
  input  logic [WIDTH-1:0] instr_address,
  output logic [WIDTH-1:0] instr_readdata,
  output logic             instr_valid,
  input  logic             data_read,
  input  logic             data_write,
  input  logic [WIDTH-1:0] data_address,
  input  logic [WIDTH-1:0] data_writedata,
  input  logic [3:0]       data_byteenable,
  output logic [WIDTH-1:0] data_readdata,
  output logic             data_valid,
  output logic [WIDTH-1:0] mem_address,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_writedata,
  output logic [3:0]       mem_byteenable,
  input  logic [WIDTH-1:0] mem_readdata,
  input  logic             mem_waitrequest,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic [WIDTH-1:0] instr_rdata_q, instr_rdata_d;
  logic [WIDTH-1:0] data_rdata_q, data_rdata_d;
  logic             instr_valid_q, instr_valid_d;
  logic             data_valid_q, data_valid_d;
  logic             busy_q, busy_d;
`ifdef MEM_ARB_RR_EN
  grant_e           last_gnt_q, last_gnt_d;
`endif

  logic             data_req_s;
  logic             any_req_s;
  grant_e           gnt_s;

  // A store wins over a simultaneous load, so either strobe means a data request.
  assign data_req_s = data_read | data_write;

  mem_arb_select u_select (
    .instr_req (instr_req),
    .data_req  (data_req_s),
`ifdef MEM_ARB_RR_EN
    .last_gnt  (last_gnt_q),
`endif
    .any_req   (any_req_s),
    .gnt       (gnt_s)
  );

  // Next-state and operand-latch logic for the IDLE/GRANT_I/GRANT_D machine.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    instr_rdata_d = instr_rdata_q;
    data_rdata_d  = data_rdata_q;
    instr_valid_d = 1'b0;
    data_valid_d  = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_gnt_d    = last_gnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          if (gnt_s == GNT_D) begin
            addr_d      = data_address;
            wdata_d     = data_writedata;
            be_d        = data_byteenable;
            mem_write_d = data_write;
            mem_read_d  = ~data_write;
            state_d     = GRANT_D;
          end else begin
            addr_d      = instr_address;
            wdata_d     = {WIDTH{1'b0}};
            be_d        = 4'hF;
            mem_write_d = 1'b0;
            mem_read_d  = 1'b1;
            state_d     = GRANT_I;
          end
`ifdef MEM_ARB_RR_EN
          last_gnt_d = gnt_s;
`endif
        end else begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      GRANT_I: begin
        if (!mem_waitrequest) begin
          instr_rdata_d = mem_readdata;
          instr_valid_d = 1'b1;
          mem_read_d    = 1'b0;
          mem_write_d   = 1'b0;
          state_d       = IDLE;
        end else begin
          state_d = GRANT_I;
        end
      end
      GRANT_D: begin
        if (!mem_waitrequest) begin
          if (!mem_write_q) begin
            data_rdata_d = mem_readdata;
          end else begin
            data_rdata_d = data_rdata_q;
          end
          data_valid_d = 1'b1;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = GRANT_D;
        end
      end
      default: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, latched operands and all outputs; reset aborts any transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= {WIDTH{1'b0}};
      wdata_q       <= {WIDTH{1'b0}};
      be_q          <= 4'h0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      instr_rdata_q <= {WIDTH{1'b0}};
      data_rdata_q  <= {WIDTH{1'b0}};
      instr_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_gnt_q    <= GNT_I;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      instr_rdata_q <= instr_rdata_d;
      data_rdata_q  <= data_rdata_d;
      instr_valid_q <= instr_valid_d;
      data_valid_q  <= data_valid_d;
      busy_q        <= busy_d;
`ifdef MEM_ARB_RR_EN
      last_gnt_q    <= last_gnt_d;
`endif
    end
  end

  assign mem_address    = addr_q;
  assign mem_writedata  = wdata_q;
  assign mem_byteenable = be_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign instr_readdata = instr_rdata_q;
  assign data_readdata  = data_rdata_q;
  assign instr_valid    = instr_valid_q;
  assign data_valid     = data_valid_q;
  assign busy           = busy_q;

endmodule
